// File: rtl/clock_ctrl_pkg.sv
// Shared constants for the clock_ctrl run/halt/single-step controller:
// state encodings and the default counter width and half-period.
package clock_ctrl_pkg;

    localparam int          CLK_CNT_W       = 27;
    localparam int unsigned CLK_DIV_DEFAULT = 2500000;

    localparam logic [1:0] HALT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] STEP = 2'd2;

endpackage

// File: rtl/clock_ctrl_div.sv
// Programmable half-period counter with a registered toggle output.
// A clear forces both the counter and the toggle low, overriding any terminal count.
module clock_ctrl_div
    import clock_ctrl_pkg::*;
#(
    parameter int CNT_W = CLK_CNT_W
) (
    input  logic             speed_clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [CNT_W-1:0] half_period,
    output logic             terminal,
    output logic             toggle
);

    logic [CNT_W-1:0] count;

    assign terminal = enable && (count == half_period - CNT_W'(1));

    always_ff @(posedge speed_clock) begin
        if (reset || clear) begin
            count  <= '0;
            toggle <= 1'b0;
        end else if (enable) begin
            if (terminal) begin
                count  <= '0;
                toggle <= ~toggle;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/clock_ctrl.sv
// Run/halt/single-step controller around clock_ctrl_div with a load/ack divisor handshake.
// Optional tick counter enabled by defining CLK_CTRL_TICK_COUNT_EN.
module clock_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int          CNT_W       = CLK_CNT_W,
    parameter int unsigned DIV_DEFAULT = CLK_DIV_DEFAULT
) (
    input  logic             speed_clock,
    input  logic             reset,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             div_ack,
    output logic             div_err,
    output logic             low_clock,
    output logic             tick,
    output logic [1:0]       state,
    output logic [15:0]      tick_count
);

    logic [CNT_W-1:0] active_div;
    logic [CNT_W-1:0] pend_div;
    logic             pend_valid;
    logic             halt_pend;
    logic             counting;
    logic             terminal;
    logic             halt_low;
    logic             fall_now;
    logic             rise_now;
    logic             apply_div;
    logic             load_ok;

    assign counting  = (state == RUN) || (state == STEP);
    // A halt during the low phase stops at once; the clear also suppresses a pending rise.
    assign halt_low  = counting && halt_req && !low_clock;
    assign fall_now  = terminal && low_clock;
    assign rise_now  = terminal && !low_clock && !halt_low;
    assign apply_div = pend_valid && ((state == HALT) || terminal);
    assign load_ok   = div_load && (div_val != '0);

    clock_ctrl_div #(
        .CNT_W(CNT_W)
    ) u_div (
        .speed_clock(speed_clock),
        .reset      (reset),
        .enable     (counting),
        .clear      (!counting || halt_low),
        .half_period(active_div),
        .terminal   (terminal),
        .toggle     (low_clock)
    );

    always_ff @(posedge speed_clock) begin
        if (reset) begin
            state     <= HALT;
            halt_pend <= 1'b0;
        end else begin
            case (state)
                HALT: begin
                    halt_pend <= 1'b0;
                    if (!halt_req && step_req) begin
                        state <= STEP;
                    end else if (!halt_req && run_req) begin
                        state <= RUN;
                    end
                end
                RUN, STEP: begin
                    // A step ends on its own falling edge, exactly like a deferred halt.
                    if (halt_low || (fall_now && (halt_pend || halt_req || state == STEP))) begin
                        state     <= HALT;
                        halt_pend <= 1'b0;
                    end else if (halt_req) begin
                        halt_pend <= 1'b1;
                    end
                end
                default: begin
                    state     <= HALT;
                    halt_pend <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge speed_clock) begin
        if (reset) begin
            tick <= 1'b0;
        end else begin
            tick <= rise_now;
        end
    end

    always_ff @(posedge speed_clock) begin
        if (reset) begin
            active_div <= CNT_W'(DIV_DEFAULT);
            pend_div   <= '0;
            pend_valid <= 1'b0;
            div_ack    <= 1'b0;
            div_err    <= 1'b0;
        end else begin
            div_ack <= apply_div;
            div_err <= div_load && (div_val == '0);
            if (apply_div) begin
                active_div <= pend_div;
            end
            // A fresh load wins over clearing the pending flag so it is not lost.
            if (load_ok) begin
                pend_div   <= div_val;
                pend_valid <= 1'b1;
            end else if (apply_div) begin
                pend_valid <= 1'b0;
            end
        end
    end

`ifdef CLK_CTRL_TICK_COUNT_EN
    always_ff @(posedge speed_clock) begin
        if (reset) begin
            tick_count <= '0;
        end else if (tick) begin
            tick_count <= tick_count + 16'd1;
        end
    end
`else
    assign tick_count = '0;
`endif

endmodule

// File: tb/tb_clock_ctrl.sv
// Scoreboard bench for clock_ctrl with a half-period of 4: expectations are queued
// against absolute cycle numbers when stimulus is driven and checked at the falling edge.
module tb_clock_ctrl;

    localparam int S_LOW   = 0;
    localparam int S_TICK  = 1;
    localparam int S_STATE = 2;
    localparam int S_ACK   = 3;
    localparam int S_ERR   = 4;
    localparam int S_TCNT  = 5;

`ifdef CLK_CTRL_TICK_COUNT_EN
    localparam int TCNT_AFTER_STEP = 3;
    localparam int TCNT_BEFORE_RST = 7;
`else
    localparam int TCNT_AFTER_STEP = 0;
    localparam int TCNT_BEFORE_RST = 0;
`endif

    typedef struct {
        int    cyc;
        int    sel;
        int    val;
        string tag;
    } exp_t;

    logic        speed_clock = 1'b0;
    logic        reset;
    logic        run_req;
    logic        halt_req;
    logic        step_req;
    logic [26:0] div_val;
    logic        div_load;
    logic        div_ack;
    logic        div_err;
    logic        low_clock;
    logic        tick;
    logic [1:0]  state;
    logic [15:0] tick_count;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    clock_ctrl #(
        .CNT_W      (27),
        .DIV_DEFAULT(4)
    ) dut (
        .speed_clock(speed_clock),
        .reset      (reset),
        .run_req    (run_req),
        .halt_req   (halt_req),
        .step_req   (step_req),
        .div_val    (div_val),
        .div_load   (div_load),
        .div_ack    (div_ack),
        .div_err    (div_err),
        .low_clock  (low_clock),
        .tick       (tick),
        .state      (state),
        .tick_count (tick_count)
    );

    always #5 speed_clock = ~speed_clock;

    always @(posedge speed_clock) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", tag, observed, expected, cyc);
        end
    endtask

    function automatic int observe(input int sel);
        case (sel)
            S_LOW:   return int'(low_clock);
            S_TICK:  return int'(tick);
            S_STATE: return int'(state);
            S_ACK:   return int'(div_ack);
            S_ERR:   return int'(div_err);
            default: return int'(tick_count);
        endcase
    endfunction

    function automatic void expectAt(input int c, input int sel, input int val, input string tag);
        exp_t e;
        e.cyc = c;
        e.sel = sel;
        e.val = val;
        e.tag = tag;
        sb.push_back(e);
    endfunction

    // Outputs after posedge number N are compared at the following negedge.
    always @(negedge speed_clock) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                checkOutput(sb[i].tag, observe(sb[i].sel), sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic h, input logic s, input logic l,
                                 input logic [26:0] v, output int req_edge);
        @(negedge speed_clock);
        run_req  = r;
        halt_req = h;
        step_req = s;
        div_load = l;
        div_val  = v;
        req_edge = cyc + 1;
    endtask

    task automatic releaseUntil(input int c);
        @(negedge speed_clock);
        run_req  = 1'b0;
        halt_req = 1'b0;
        step_req = 1'b0;
        div_load = 1'b0;
        div_val  = '0;
        while (cyc < c) @(negedge speed_clock);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e, h, s, r, l, g, t, u, x;
        reset    = 1'b1;
        run_req  = 1'b0;
        halt_req = 1'b0;
        step_req = 1'b0;
        div_load = 1'b0;
        div_val  = '0;

        expectAt(2, S_STATE, 0, "rst_state");
        expectAt(2, S_LOW,   0, "rst_low");
        expectAt(2, S_TICK,  0, "rst_tick");
        expectAt(2, S_ACK,   0, "rst_ack");
        expectAt(2, S_ERR,   0, "rst_err");
        expectAt(2, S_TCNT,  0, "rst_tcnt");
        while (cyc < 3) @(negedge speed_clock);
        reset = 1'b0;

        // Free run: first rise 4 cycles after the request, period 8.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, e);
        expectAt(e, S_STATE, 1, "run_state");
        for (int k = 0; k <= 12; k++) begin
            expectAt(e + k, S_LOW,  (k >= 4 && ((k - 4) / 4) % 2 == 0) ? 1 : 0, "run_low");
            expectAt(e + k, S_TICK, (k >= 4 && (k - 4) % 8 == 0) ? 1 : 0, "run_tick");
        end
        releaseUntil(e + 12);

        // Halt in the high phase with the counter at 1: finish the high phase first.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, h);
        for (int c = h; c <= h + 8; c++) begin
            expectAt(c, S_STATE, (c < h + 2) ? 1 : 0, "halt_state");
            expectAt(c, S_LOW,   (c < h + 2) ? 1 : 0, "halt_low");
            expectAt(c, S_TICK,  0, "halt_tick");
        end
        releaseUntil(h + 8);

        // Single step: one full period, one tick, back to HALT after 8 cycles.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, s);
        for (int c = s; c <= s + 10; c++) begin
            expectAt(c, S_STATE, (c < s + 8) ? 2 : 0, "step_state");
            expectAt(c, S_LOW,   (c >= s + 4 && c < s + 8) ? 1 : 0, "step_low");
            expectAt(c, S_TICK,  (c == s + 4) ? 1 : 0, "step_tick");
        end
        expectAt(s + 10, S_TCNT, TCNT_AFTER_STEP, "step_tcnt");
        releaseUntil(s + 10);

        // Rejected zero divisor: error pulse, no ack, period stays 8.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, r);
        expectAt(r, S_STATE, 1, "run2_state");
        expectAt(r + 4, S_TICK, 1, "run2_tick");
        expectAt(r + 4, S_ERR, 0, "err_before");
        expectAt(r + 5, S_ERR, 1, "err_pulse");
        expectAt(r + 6, S_ERR, 0, "err_after");
        expectAt(r + 8, S_ACK, 0, "err_no_ack");
        for (int c = r + 8; c <= r + 15; c++) begin
            expectAt(c, S_LOW, (c >= r + 12) ? 1 : 0, "err_low");
        end
        expectAt(r + 12, S_TICK, 1, "err_tick");
        releaseUntil(r + 3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0, l);
        releaseUntil(r + 12);

        // Divisor 2 loaded mid high phase: ack at the next terminal count, then period 4.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 27'd2, l);
        expectAt(l + 1, S_ACK, 0, "ack_before");
        expectAt(l + 2, S_ACK, 1, "ack_pulse");
        expectAt(l + 3, S_ACK, 0, "ack_after");
        for (int c = l + 2; c <= l + 9; c++) begin
            expectAt(c, S_LOW, ((c - l - 2) / 2) % 2, "div2_low");
        end
        expectAt(l + 4, S_TICK, 1, "div2_tick");
        expectAt(l + 5, S_TICK, 0, "div2_tick_off");
        expectAt(l + 8, S_TICK, 1, "div2_tick2");
        releaseUntil(l + 9);

        // Halt and run together during a low phase: halt wins, rise is aborted.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, g);
        for (int c = g; c <= g + 4; c++) begin
            expectAt(c, S_STATE, 0, "prio_state");
            expectAt(c, S_LOW,   0, "prio_low");
        end
        expectAt(g + 1, S_TICK, 0, "prio_tick");
        releaseUntil(g + 4);

        // Step, queue a divisor load, then reset in the high phase.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, t);
        expectAt(t,     S_STATE, 2, "step2_state");
        expectAt(t + 2, S_LOW,   1, "step2_low");
        expectAt(t + 2, S_TICK,  1, "step2_tick");
        expectAt(t + 2, S_TCNT,  TCNT_BEFORE_RST, "step2_tcnt");
        releaseUntil(t);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 27'd3, l);
        @(negedge speed_clock);
        div_load = 1'b0;
        div_val  = '0;
        reset    = 1'b1;
        x = cyc + 1;
        expectAt(x, S_STATE, 0, "mrst_state");
        expectAt(x, S_LOW,   0, "mrst_low");
        expectAt(x, S_TICK,  0, "mrst_tick");
        expectAt(x, S_ACK,   0, "mrst_ack");
        expectAt(x, S_ERR,   0, "mrst_err");
        expectAt(x, S_TCNT,  0, "mrst_tcnt");
        expectAt(x + 1, S_ACK, 0, "mrst_no_ack1");
        expectAt(x + 2, S_ACK, 0, "mrst_no_ack2");
        @(negedge speed_clock);
        reset = 1'b0;

        // After reset the default half-period is back and the queued load is gone.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, u);
        expectAt(u,     S_STATE, 1, "post_state");
        expectAt(u + 3, S_LOW,   0, "post_low3");
        expectAt(u + 4, S_LOW,   1, "post_low4");
        expectAt(u + 4, S_TICK,  1, "post_tick");
        expectAt(u + 7, S_LOW,   1, "post_low7");
        expectAt(u + 8, S_LOW,   0, "post_low8");
        releaseUntil(u + 10);

        @(posedge speed_clock);
        #1;
        checkOutput("sb_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
